// File: rtl/bp_be_mmu_arb_pkg.sv
//------------------------------------------------------------------------------
// Module : bp_be_mmu_arb_pkg
// Brief  : Shared types and constants for the BE MMU port arbiter:
//          arbiter state encoding, requester count, and the packed MMU
//          command/response formats with their derived widths.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bp_be_mmu_arb_pkg;

   localparam int bp_be_mmu_arb_reqs_gp = 2;

   typedef enum logic [0:0] {
      e_mmu_arb_idle = 1'b0,
      e_mmu_arb_busy = 1'b1
   } bp_be_mmu_arb_state_e;

   typedef struct packed {
      logic [3:0]  mem_op;
      logic [63:0] vaddr;
      logic [63:0] data;
   } bp_be_mmu_cmd_s;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  exc;
   } bp_be_mmu_resp_s;

   localparam int bp_be_mmu_cmd_width_gp  = $bits(bp_be_mmu_cmd_s);
   localparam int bp_be_mmu_resp_width_gp = $bits(bp_be_mmu_resp_s);

endpackage

`default_nettype wire

// File: rtl/bp_be_mmu_arb_rr.sv
//------------------------------------------------------------------------------
// Module : bp_be_mmu_arb_rr
// Brief  : Two-input round-robin grant. The pointer selects the winner when
//          both inputs are valid and moves to the loser only on fire_i.
// Ports  : clk_i, reset_i  - clock, synchronous active-high reset
//          v_i[1:0]        - request valids
//          fire_i          - granted request was accepted this cycle
//          grant_o         - index of the granted requester
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bp_be_mmu_arb_rr
   import bp_be_mmu_arb_pkg::*;
(
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [bp_be_mmu_arb_reqs_gp-1:0] v_i,
   input  logic                             fire_i,
   output logic                             grant_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      grant_o = 1'b0;
      if (v_i[0] && v_i[1]) begin
         grant_o = ptr_q;
      end else if (v_i[1]) begin
         grant_o = 1'b1;
      end
      ptr_d = ptr_q;
      if (fire_i) begin
         // Favour the requester that just lost.
         ptr_d = ~grant_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bp_be_mmu_arb.sv
//------------------------------------------------------------------------------
// Module : bp_be_mmu_arb
// Brief  : Shares one BE MMU command/response port between the pipeline mem
//          stage (requester 0) and an auxiliary agent (requester 1). Round-
//          robin grant, one command outstanding, response routed to issuer,
//          flush drops requester 0's pending response.
// Ports  : clk_i, reset_i                 - clock, sync active-high reset
//          cmd{0,1}_i/_v_i/_ready_o       - requester command handshakes
//          flush_i                        - cancel requester 0 response
//          mmu_cmd_o/_v_o/_ready_i        - command to MMU
//          mmu_resp_i/_v_i                - MMU response pulse
//          resp{0,1}_o/_v_o               - routed responses
//          timeout_o                      - sticky watchdog error (optional)
// Macro  : BP_BE_MMU_ARB_WATCHDOG_EN enables the BUSY watchdog and timeout_o.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bp_be_mmu_arb
   import bp_be_mmu_arb_pkg::*;
#(
   parameter int cmd_width_p      = bp_be_mmu_cmd_width_gp,
   parameter int resp_width_p     = bp_be_mmu_resp_width_gp,
   parameter int timeout_cycles_p = 255
)
(
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [cmd_width_p-1:0]  cmd0_i,
   input  logic                    cmd0_v_i,
   output logic                    cmd0_ready_o,
   input  logic [cmd_width_p-1:0]  cmd1_i,
   input  logic                    cmd1_v_i,
   output logic                    cmd1_ready_o,
   input  logic                    flush_i,
   output logic [cmd_width_p-1:0]  mmu_cmd_o,
   output logic                    mmu_cmd_v_o,
   input  logic                    mmu_cmd_ready_i,
   input  logic [resp_width_p-1:0] mmu_resp_i,
   input  logic                    mmu_resp_v_i,
   output logic [resp_width_p-1:0] resp0_o,
   output logic                    resp0_v_o,
   output logic [resp_width_p-1:0] resp1_o,
   output logic                    resp1_v_o
`ifdef BP_BE_MMU_ARB_WATCHDOG_EN
   ,
   output logic                    timeout_o
`endif
);

   bp_be_mmu_arb_state_e state_q, state_d;
   logic owner_q, owner_d;
   logic drop_q, drop_d;
   logic fire;
   logic grant;

`ifdef BP_BE_MMU_ARB_WATCHDOG_EN
   localparam int cnt_width_lp = $clog2(timeout_cycles_p + 1);
   logic [cnt_width_lp-1:0] cnt_q, cnt_d;
   logic                    timeout_q, timeout_d;
   assign timeout_o = timeout_q;
`else
   localparam int unused_timeout_lp = timeout_cycles_p;
`endif

   bp_be_mmu_arb_rr u_rr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     ({cmd1_v_i, cmd0_v_i}),
      .fire_i  (fire),
      .grant_o (grant)
   );

   // Data paths are plain muxes; only the valids carry meaning.
   assign mmu_cmd_o = grant ? cmd1_i : cmd0_i;
   assign resp0_o   = mmu_resp_i;
   assign resp1_o   = mmu_resp_i;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      drop_d       = drop_q;
      mmu_cmd_v_o  = 1'b0;
      fire         = 1'b0;
      cmd0_ready_o = 1'b0;
      cmd1_ready_o = 1'b0;
      resp0_v_o    = 1'b0;
      resp1_v_o    = 1'b0;
`ifdef BP_BE_MMU_ARB_WATCHDOG_EN
      cnt_d        = cnt_q;
      timeout_d    = timeout_q;
`endif
      case (state_q)
         e_mmu_arb_idle: begin
            mmu_cmd_v_o  = cmd0_v_i | cmd1_v_i;
            fire         = mmu_cmd_v_o & mmu_cmd_ready_i;
            cmd0_ready_o = fire & ~grant;
            cmd1_ready_o = fire &  grant;
            if (fire) begin
               owner_d = grant;
               state_d = e_mmu_arb_busy;
               // A flush coinciding with a requester 0 fire already
               // cancels the response of the command being issued.
               drop_d  = flush_i & ~grant;
`ifdef BP_BE_MMU_ARB_WATCHDOG_EN
               cnt_d   = '0;
`endif
            end
         end
         e_mmu_arb_busy: begin
            if (flush_i && !owner_q) begin
               drop_d = 1'b1;
            end
            if (mmu_resp_v_i) begin
               resp0_v_o = ~owner_q & ~drop_q;
               resp1_v_o =  owner_q;
               state_d   = e_mmu_arb_idle;
               drop_d    = 1'b0;
            end
`ifdef BP_BE_MMU_ARB_WATCHDOG_EN
            else if (cnt_q == cnt_width_lp'(timeout_cycles_p - 1)) begin
               // This BUSY cycle is the timeout_cycles_p-th without reply.
               timeout_d = 1'b1;
               state_d   = e_mmu_arb_idle;
               drop_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + cnt_width_lp'(1);
            end
`endif
         end
         default: begin
            state_d = e_mmu_arb_idle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= e_mmu_arb_idle;
         owner_q   <= 1'b0;
         drop_q    <= 1'b0;
`ifdef BP_BE_MMU_ARB_WATCHDOG_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         drop_q    <= drop_d;
`ifdef BP_BE_MMU_ARB_WATCHDOG_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

endmodule

`default_nettype wire

// File: doc/bp_be_mmu_arb.md
Name: bp_be_mmu_arb

Overview:
- Shares the single BE MMU command/response port between two requesters.
  - Requester 0: pipeline memory stage.
  - Requester 1: auxiliary agent (PTW / fence / debug).
- Round-robin grant; at most one command outstanding at the MMU.
- Each MMU response is routed back to the requester that issued it.
- Pipeline flushes can cancel requester 0's in-flight response.
- Sits between the calculator mem pipe and the MMU; traffic uses the bp_be_mmu_cmd_s / bp_be_mmu_resp_s packed formats.

Parameters:
- cmd_width_p, `bp_be_mmu_cmd_width: packed MMU command width.
- resp_width_p, `bp_be_mmu_resp_width: packed MMU response width.
- timeout_cycles_p, 255: watchdog limit in cycles; only used with the optional feature; must be >= 1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- cmd0_i  in  cmd_width_p  requester 0 command (bp_be_mmu_cmd_s)
- cmd0_v_i  in  1  requester 0 command valid
- cmd0_ready_o  out  1  requester 0 command accepted this cycle
- cmd1_i  in  cmd_width_p  requester 1 command
- cmd1_v_i  in  1  requester 1 command valid
- cmd1_ready_o  out  1  requester 1 command accepted this cycle
- flush_i  in  1  cancel requester 0's outstanding or same-cycle-accepted command response
- mmu_cmd_o  out  cmd_width_p  command to MMU
- mmu_cmd_v_o  out  1  MMU command valid
- mmu_cmd_ready_i  in  1  MMU can accept a command
- mmu_resp_i  in  resp_width_p  MMU response (bp_be_mmu_resp_s)
- mmu_resp_v_i  in  1  MMU response valid; one-cycle pulse, no backpressure
- resp0_o  out  resp_width_p  response to requester 0
- resp0_v_o  out  1  response to requester 0 valid
- resp1_o  out  resp_width_p  response to requester 1
- resp1_v_o  out  1  response to requester 1 valid
- timeout_o  out  1  sticky watchdog error; present only with the optional feature

Behaviour:
- Clock and reset: one clock clk_i; reset_i is synchronous, active-high.
- Reset values:
  - State = IDLE; owner = 0; drop = 0.
  - Round-robin pointer favours requester 0.
  - All *_v_o, ready outputs and timeout_o are 0.
  - mmu_cmd_o, resp0_o, resp1_o are don't-care while their valids are 0.
- States: IDLE, BUSY.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester favoured by the pointer.
  - mmu_cmd_v_o = cmd0_v_i | cmd1_v_i.
  - mmu_cmd_o = granted command (combinational mux, zero latency).
  - Granted requester's ready_o = mmu_cmd_ready_i; the other requester's ready_o = 0.
  - On fire (mmu_cmd_v_o & mmu_cmd_ready_i):
    - owner <= grant.
    - Pointer <= favour the non-granted requester.
    - Go to BUSY.
- BUSY:
  - mmu_cmd_v_o = 0; both ready_o = 0.
  - On mmu_resp_v_i:
    - mmu_resp_i is passed to resp{owner}_o with resp{owner}_v_o asserted in the same cycle, unless drop = 1 and owner = 0; in that case the response is absorbed and no valid is raised.
    - Then go to IDLE and clear drop.
  - mmu_resp_v_i while in IDLE is ignored.
- Throughput: minimum command-to-command spacing is 2 cycles (fire, response, then next fire). A new command is never accepted in the same cycle as a response.
- Flush:
  - flush_i in BUSY with owner = 0 sets drop.
  - flush_i in the same cycle as a requester 0 fire also sets drop.
  - flush_i has no effect on requester 1 traffic.
  - flush_i in IDLE with no fire has no effect.
  - The command itself is never retracted from the MMU.
- Reset mid-operation: returns to IDLE immediately. A late MMU response arriving afterwards is ignored, because IDLE ignores responses.
- Requester 1 is never starved: after one requester 0 grant, a valid requester 1 wins the next contended grant.

Optional Feature:
- Macro: BP_BE_MMU_ARB_WATCHDOG_EN.
- Defined:
  - Counter of width $clog2(timeout_cycles_p+1), cleared on the fire into BUSY and incremented each BUSY cycle without a response.
  - When the counter reaches timeout_cycles_p: timeout_o <= 1 (sticky until reset) and the state returns to IDLE with no response delivered.
  - A later stray response is ignored.
- Undefined: no counter; timeout_o port is absent; BUSY waits indefinitely.

Decomposition:
- bp_be_pkg additions:
  - bp_be_mmu_arb_state_e enum {e_mmu_arb_idle, e_mmu_arb_busy}.
  - Localparam bp_be_mmu_arb_reqs_gp = 2.
- Sub-module bp_be_mmu_arb_rr: two-input round-robin grant with pointer register, advanced only on a fire strobe.

Test Plan:
- Single requester: cmd0 (addr 0x80000124) valid, mmu_cmd_ready_i = 1 → mmu_cmd_o equals cmd0 in the same cycle; cmd0_ready_o = 1; response arriving 3 cycles later appears on resp0_o with resp0_v_o for exactly 1 cycle; resp1_v_o stays 0.
- Contention: both valid continuously, MMU responds 1 cycle after each fire → grant order 0,1,0,1; fires on cycles 0, 2, 4, 6.
- Backpressure: both valid, mmu_cmd_ready_i = 0 for 5 cycles → no ready_o asserted and no state change; pointer still favours requester 0 when ready rises.
- Flush: requester 0 fires, flush_i pulsed 1 cycle later, response arrives → resp0_v_o stays 0 and the arbiter returns to IDLE; repeating with requester 1 as owner still delivers resp1_v_o.
- Reset mid-op: reset_i asserted in BUSY, then a response arrives 2 cycles after reset deasserts → no resp*_v_o; the next cmd1 fires normally.
- With BP_BE_MMU_ARB_WATCHDOG_EN and timeout_cycles_p = 4, no response after a fire → timeout_o rises after 4 BUSY cycles; the next command is accepted in the following cycle.
